// File: rtl/uart_rx_fifo_ctrl_pkg.sv
// rtl/uart_rx_fifo_ctrl_pkg.sv - shared UART receive-FIFO types and defaults
//
// Holds the UART data/baud widths, the default FIFO depth and timeout length,
// and the timeout state encoding used by uart_rx_fifo_ctrl.
package uart_rx_fifo_ctrl_pkg;

    localparam int UART_DATA_SIZE         = 8;
    localparam int UART_BAUD_DIV_SIZE     = 16;
    localparam int UART_BITS_PER_CHAR     = 10;   // start + 8 data + stop
    localparam int UART_RXF_DEPTH         = 8;
    localparam int UART_RXF_TIMEOUT_CHARS = 4;

    typedef enum logic [1:0] {
        TO_IDLE  = 2'd0,
        TO_COUNT = 2'd1,
        TO_FIRED = 2'd2
    } type_uart_rxf_to_states_e;

    // Converts an idle time expressed in characters into bit times.
    function automatic int to_bits(input int chars);
        return chars * UART_BITS_PER_CHAR;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// rtl/uart_rx_fifo_ctrl_if.sv - receive-side and host-side signals of the RX FIFO controller
//
// master : the UART receiver / host side (drives bytes, pops, configuration)
// slave  : uart_rx_fifo_ctrl (returns head data, occupancy and status)
interface uart_rx_fifo_ctrl_if
    import uart_rx_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = UART_RXF_DEPTH
) ();

    localparam int CW = $clog2(DEPTH + 1);

    logic [UART_DATA_SIZE-1:0]     rx_data_i;
    logic                          rx_valid_i;
    logic                          rx_frame_err_i;
    logic [UART_BAUD_DIV_SIZE-1:0] baud_div_i;
    logic                          rd_en_i;
    logic [UART_DATA_SIZE-1:0]     rd_data_o;
    logic [CW-1:0]                 thresh_i;
    logic                          clr_i;
    logic                          err_clr_i;
    logic [CW-1:0]                 count_o;
    logic                          empty_o;
    logic                          full_o;
    logic                          overrun_o;
    logic                          frame_err_o;
    logic                          timeout_o;
    logic                          irq_o;

    modport master (
        output rx_data_i, rx_valid_i, rx_frame_err_i, baud_div_i, rd_en_i,
               thresh_i, clr_i, err_clr_i,
        input  rd_data_o, count_o, empty_o, full_o, overrun_o, frame_err_o,
               timeout_o, irq_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, rx_frame_err_i, baud_div_i, rd_en_i,
               thresh_i, clr_i, err_clr_i,
        output rd_data_o, count_o, empty_o, full_o, overrun_o, frame_err_o,
               timeout_o, irq_o
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset (pointers/count only)
//   i_clr      flush: zero pointers and count, overrides write/read
//   i_wr_en    write i_wr_data at tail (accepted when not full, or full with a read)
//   i_rd_en    pop head (ignored when empty)
//   o_rd_data  head entry, meaningful only while o_empty is low
//   o_count    occupancy 0..DEPTH; o_empty / o_full derived from it
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    // DEPTH must be a power of two so the pointers wrap naturally.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_rd;
    logic             w_wr;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // A read frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_rd = i_rd_en & ~o_empty & ~i_clr;
    assign w_wr = i_wr_en & (~o_full | w_rd) & ~i_clr;

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - UART receive FIFO with error flags, RX timeout and interrupt
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        uart_rx_fifo_ctrl_if.slave:
//              rx_data_i/rx_valid_i/rx_frame_err_i  incoming bytes from the receiver
//              rd_en_i/rd_data_o                    show-ahead pop port
//              baud_div_i                           clocks per bit (0 treated as 1)
//              thresh_i                             level interrupt threshold, 0 = off
//              clr_i/err_clr_i                      flush FIFO / clear sticky errors
//              count_o/empty_o/full_o               occupancy
//              overrun_o/frame_err_o/timeout_o/irq_o status and interrupt
module uart_rx_fifo_ctrl
    import uart_rx_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH         = UART_RXF_DEPTH,
    parameter int TIMEOUT_CHARS = UART_RXF_TIMEOUT_CHARS
) (
    input logic               clk,
    input logic               rst,
    uart_rx_fifo_ctrl_if.slave bus
);

    localparam int CW      = $clog2(DEPTH + 1);
    localparam int TO_BITS = to_bits(TIMEOUT_CHARS);
    localparam int BW      = $clog2(TO_BITS + 1);
    localparam logic [UART_BAUD_DIV_SIZE-1:0] DIV_ONE = UART_BAUD_DIV_SIZE'(1);

    type_uart_rxf_to_states_e r_state, w_state_next;

    logic [UART_BAUD_DIV_SIZE-1:0] r_presc, w_presc_next;
    logic [BW-1:0]                 r_bits, w_bits_next;
    logic [UART_BAUD_DIV_SIZE-1:0] w_div_m1;
    logic                          w_tick;

    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_next;
    logic          w_empty;
    logic          w_full;

    logic w_push_req;
    logic w_push;
    logic w_pop;
    logic w_activity;
    logic w_ovr_evt;
    logic w_fe_evt;

    logic r_overrun, w_overrun_next;
    logic r_frame_err, w_frame_err_next;
    logic r_irq, w_irq_next;

    // Accepted push/pop for this cycle; a flush cancels both.
    assign w_push_req = bus.rx_valid_i & ~bus.rx_frame_err_i;
    assign w_pop      = bus.rd_en_i & ~w_empty & ~bus.clr_i;
    assign w_push     = w_push_req & (~w_full | bus.rd_en_i) & ~bus.clr_i;
    assign w_activity = w_push | w_pop;

    // Full with a same-cycle read is not an overrun: the read makes room.
    assign w_ovr_evt = w_push_req & w_full & ~bus.rd_en_i;
    assign w_fe_evt  = bus.rx_valid_i & bus.rx_frame_err_i;

    uart_sync_fifo #(
        .WIDTH (UART_DATA_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (bus.clr_i),
        .i_wr_en   (w_push),
        .i_wr_data (bus.rx_data_i),
        .i_rd_en   (w_pop),
        .o_rd_data (bus.rd_data_o),
        .o_count   (w_count),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    // Occupancy one cycle ahead, so the level interrupt lines up with count_o.
    always_comb begin
        w_count_next = w_count;
        if (bus.clr_i) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = w_count + CW'(1);
                2'b01:   w_count_next = w_count - CW'(1);
                default: w_count_next = w_count;
            endcase
        end
    end

    // A new error in the same cycle as the clear keeps the flag set.
    assign w_overrun_next   = w_ovr_evt | (r_overrun & ~bus.err_clr_i);
    assign w_frame_err_next = w_fe_evt  | (r_frame_err & ~bus.err_clr_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_overrun_next;
            r_frame_err <= w_frame_err_next;
        end
    end

    // Prescaler wraps after baud_div_i clocks; a divider of 0 behaves as 1.
    assign w_div_m1 = (bus.baud_div_i == '0) ? '0 : (bus.baud_div_i - DIV_ONE);
    assign w_tick   = (r_presc >= w_div_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TO_IDLE;
            r_presc <= '0;
            r_bits  <= '0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            r_bits  <= w_bits_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_presc_next = r_presc;
        w_bits_next  = r_bits;
        if (bus.clr_i) begin
            w_state_next = TO_IDLE;
            w_presc_next = '0;
            w_bits_next  = '0;
        end else begin
            case (r_state)
                TO_IDLE: begin
                    w_presc_next = '0;
                    w_bits_next  = '0;
                    if (!w_empty) begin
                        w_state_next = TO_COUNT;
                    end
                end
                TO_COUNT: begin
                    if (w_empty) begin
                        w_state_next = TO_IDLE;
                        w_presc_next = '0;
                        w_bits_next  = '0;
                    end else if (w_activity) begin
                        w_presc_next = '0;
                        w_bits_next  = '0;
                    end else if (w_tick) begin
                        w_presc_next = '0;
                        // Firing on the last tick means the idle span is TO_BITS bit times.
                        if (r_bits == BW'(TO_BITS - 1)) begin
                            w_state_next = TO_FIRED;
                            w_bits_next  = '0;
                        end else begin
                            w_bits_next = r_bits + BW'(1);
                        end
                    end else begin
                        w_presc_next = r_presc + DIV_ONE;
                    end
                end
                TO_FIRED: begin
                    w_presc_next = '0;
                    w_bits_next  = '0;
                    if (w_empty) begin
                        w_state_next = TO_IDLE;
                    end else if (w_activity) begin
                        w_state_next = TO_COUNT;
                    end
                end
                default: begin
                    w_state_next = TO_IDLE;
                    w_presc_next = '0;
                    w_bits_next  = '0;
                end
            endcase
        end
    end

    // Built from next-state values so irq_o rises together with the flag or
    // level that caused it, one cycle after the causing event.
    assign w_irq_next = ((bus.thresh_i != '0) && (w_count_next >= bus.thresh_i))
                      | (w_state_next == TO_FIRED)
                      | w_overrun_next
                      | w_frame_err_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_next;
        end
    end

    assign bus.count_o     = w_count;
    assign bus.empty_o     = w_empty;
    assign bus.full_o      = w_full;
    assign bus.overrun_o   = r_overrun;
    assign bus.frame_err_o = r_frame_err;
    assign bus.timeout_o   = (r_state == TO_FIRED);
    assign bus.irq_o       = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb/tb_uart_rx_fifo_ctrl.sv - directed scoreboard bench for uart_rx_fifo_ctrl
module tb_uart_rx_fifo_ctrl;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_rx_fifo_ctrl_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo_ctrl #(
        .DEPTH         (DEPTH),
        .TIMEOUT_CHARS (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        if (sb.size() < DEPTH) sb.push_back(b);
        tick();
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] e;
        e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        chk(tag, {24'b0, bus.rd_data_o}, {24'b0, e});
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
    endtask

    task automatic wait_timeout(input string tag, input int exp_cyc);
        int n;
        n = 0;
        while (bus.timeout_o !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        n_checks++;
        assert (n >= exp_cyc - 1 && n <= exp_cyc + 1) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d+-1", tag, n, exp_cyc);
        end
    endtask

    initial begin
        bus.rx_data_i      = '0;
        bus.rx_valid_i     = 1'b0;
        bus.rx_frame_err_i = 1'b0;
        bus.baud_div_i     = 16'd16;
        bus.rd_en_i        = 1'b0;
        bus.thresh_i       = '0;
        bus.clr_i          = 1'b0;
        bus.err_clr_i      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count",     bus.count_o,     0);
        chk("rst_empty",     bus.empty_o,     1);
        chk("rst_full",      bus.full_o,      0);
        chk("rst_overrun",   bus.overrun_o,   0);
        chk("rst_frame_err", bus.frame_err_o, 0);
        chk("rst_timeout",   bus.timeout_o,   0);
        chk("rst_irq",       bus.irq_o,       0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
        chk("fill_full",  bus.full_o,  1);
        chk("fill_count", bus.count_o, 8);

        push(8'hAA);
        chk("ovr_flag",  bus.overrun_o, 1);
        chk("ovr_irq",   bus.irq_o,     1);
        chk("ovr_head",  bus.rd_data_o, 8'h11);
        chk("ovr_count", bus.count_o,   8);
        bus.err_clr_i = 1'b1;
        tick();
        bus.err_clr_i = 1'b0;
        chk("ovr_clr",     bus.overrun_o, 0);
        chk("ovr_clr_irq", bus.irq_o,     0);

        for (int i = 0; i < 8; i++) pop_chk("drain1");
        chk("drain1_empty", bus.empty_o, 1);

        for (int i = 0; i < 8; i++) push(8'(8'h21 + i));
        chk("swap_head", bus.rd_data_o, {24'b0, sb.pop_front()});
        sb.push_back(8'h55);
        bus.rx_data_i  = 8'h55;
        bus.rx_valid_i = 1'b1;
        bus.rd_en_i    = 1'b1;
        tick();
        bus.rx_valid_i = 1'b0;
        bus.rd_en_i    = 1'b0;
        chk("swap_count",   bus.count_o,   8);
        chk("swap_overrun", bus.overrun_o, 0);
        for (int i = 0; i < 7; i++) pop_chk("drain2");
        chk("last_is_55", bus.rd_data_o, 8'h55);
        pop_chk("drain2_last");
        chk("drain2_empty", bus.empty_o, 1);

        bus.rx_data_i      = 8'h3C;
        bus.rx_valid_i     = 1'b1;
        bus.rx_frame_err_i = 1'b1;
        tick();
        bus.rx_valid_i     = 1'b0;
        bus.rx_frame_err_i = 1'b0;
        chk("fe_flag",  bus.frame_err_o, 1);
        chk("fe_count", bus.count_o,     0);
        chk("fe_irq",   bus.irq_o,       1);
        bus.rx_valid_i     = 1'b1;
        bus.rx_frame_err_i = 1'b1;
        bus.err_clr_i      = 1'b1;
        tick();
        bus.rx_valid_i     = 1'b0;
        bus.rx_frame_err_i = 1'b0;
        chk("fe_wins_clr", bus.frame_err_o, 1);
        tick();
        bus.err_clr_i = 1'b0;
        chk("fe_clr", bus.frame_err_o, 0);

        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        chk("empty_pop_count", bus.count_o, 0);
        chk("empty_pop_empty", bus.empty_o, 1);

        bus.rx_data_i  = 8'h66;
        bus.rx_valid_i = 1'b1;
        bus.rd_en_i    = 1'b1;
        sb.push_back(8'h66);
        tick();
        bus.rx_valid_i = 1'b0;
        bus.rd_en_i    = 1'b0;
        chk("empty_pushpop_count", bus.count_o, 1);
        pop_chk("empty_pushpop_data");

        push(8'hA5);
        chk("to_count1", bus.count_o, 1);
        wait_timeout("to_latency_div16", 640);
        chk("to_irq", bus.irq_o, 1);
        pop_chk("to_pop");
        chk("to_low_after_pop", bus.timeout_o, 0);

        bus.baud_div_i = '0;
        push(8'h5A);
        wait_timeout("to_latency_div0", 40);
        pop_chk("to_div0_pop");
        bus.baud_div_i = 16'd16;

        push(8'h01);
        push(8'h02);
        bus.clr_i      = 1'b1;
        bus.rx_data_i  = 8'h77;
        bus.rx_valid_i = 1'b1;
        tick();
        bus.clr_i      = 1'b0;
        bus.rx_valid_i = 1'b0;
        sb.delete();
        chk("clr_count", bus.count_o, 0);
        chk("clr_empty", bus.empty_o, 1);

        bus.thresh_i = 3;
        push(8'hC1);
        chk("thr_irq1", bus.irq_o, 0);
        push(8'hC2);
        chk("thr_irq2", bus.irq_o, 0);
        push(8'hC3);
        chk("thr_irq3", bus.irq_o, 1);
        push(8'hC4);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("mid_rst_count",     bus.count_o,     0);
        chk("mid_rst_empty",     bus.empty_o,     1);
        chk("mid_rst_full",      bus.full_o,      0);
        chk("mid_rst_overrun",   bus.overrun_o,   0);
        chk("mid_rst_frame_err", bus.frame_err_o, 0);
        chk("mid_rst_timeout",   bus.timeout_o,   0);
        chk("mid_rst_irq",       bus.irq_o,       0);
        tick();
        rst = 1'b0;
        bus.thresh_i = '0;
        tick();

        push(8'h99);
        pop_chk("post_rst_data");
        chk("post_rst_empty", bus.empty_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
